pcap_stream_arbiter: RTL

Frame-granular round-robin arbiter that merges several capture streams (one per tapped Ethernet port, each already converted to a byte-wide AXI-Stream of frame data) onto the single shared PCAP output path. It owns the shared downstream datapath. It grants it to one input for a whole frame, tags every output beat with the source port index, and provides a registered output stage so downstream timing is isolated.

---
 rtl/pcap_stream_arbiter_if.sv | 31 +++
 rtl/pcap_stream_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pcap_stream_arbiter_if.sv
// Bundle of the per-port capture streams and the merged PCAP output stream.
// The arbiter connects through the slave modport; the traffic environment
// (port capture logic and PCAP writer) connects through the master modport.
interface pcap_stream_arbiter_if #(
    parameter int unsigned PORTS      = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 1
);
    logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [PORTS-1:0]            s_axis_tvalid;
    logic [PORTS-1:0]            s_axis_tready;
    logic [PORTS-1:0]            s_axis_tlast;
    logic [PORTS-1:0]            s_axis_tuser;

    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        m_axis_tlast;
    logic                        m_axis_tuser;
    logic [ID_WIDTH-1:0]         m_axis_tid;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tid
    );
endinterface

// File: rtl/pcap_stream_arbiter.sv
// Frame-granular round-robin arbiter: merges PORTS byte streams onto one
// registered PCAP output, tagging each beat with its source port index.
// A port keeps the grant from its first beat through its tlast beat.
module pcap_stream_arbiter #(
    parameter int unsigned PORTS      = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pcap_stream_arbiter_if.slave axis,
    output logic                 busy
);

    if (PORTS < 2) begin : g_chk_ports
        $error("pcap_stream_arbiter: PORTS must be at least 2");
    end
    if ((64'd1 << ID_WIDTH) < 64'(PORTS)) begin : g_chk_id
        $error("pcap_stream_arbiter: ID_WIDTH too narrow for PORTS");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;

    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic                  tvalid_q, tvalid_d;

    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  sel_tvalid;
    logic                  sel_tlast;
    logic                  sel_tuser;

    logic [ID_WIDTH-1:0]   rr_pick;
    int unsigned           rr_best;

    logic [PORTS-1:0]      s_tready;
    logic                  room;
    logic                  load;

    // Round-robin pick: the valid port at the smallest rotational distance
    // after last_grant wins (distance 0 is last_grant+1).
    always_comb begin
        rr_pick = '0;
        rr_best = PORTS;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (axis.s_axis_tvalid[p] &&
                (((p + PORTS - 32'(last_grant_q) - 1) % PORTS) < rr_best)) begin
                rr_best = (p + PORTS - 32'(last_grant_q) - 1) % PORTS;
                rr_pick = ID_WIDTH'(p);
            end
        end
    end

    // Mux the granted port's stream onto the shared datapath.
    always_comb begin
        sel_tdata  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tuser  = 1'b0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (ID_WIDTH'(p) == grant_q) begin
                sel_tdata  = axis.s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_tvalid = axis.s_axis_tvalid[p];
                sel_tlast  = axis.s_axis_tlast[p];
                sel_tuser  = axis.s_axis_tuser[p];
            end
        end
    end

    // Next-state, ready generation and output-register update.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        tid_d        = tid_q;
        tvalid_d     = tvalid_q;
        s_tready     = '0;

        // Single output stage, no skid: accept only if it is empty or draining.
        room = !tvalid_q || axis.m_axis_tready;
        load = (state_q == BUSY) && room && sel_tvalid;

        for (int unsigned p = 0; p < PORTS; p++) begin
            if ((state_q == BUSY) && (ID_WIDTH'(p) == grant_q)) begin
                s_tready[p] = room;
            end
        end

        if (tvalid_q && axis.m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (|axis.s_axis_tvalid) begin
                    grant_d = rr_pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (load) begin
                    tdata_d  = sel_tdata;
                    tlast_d  = sel_tlast;
                    tuser_d  = sel_tuser;
                    tid_d    = grant_q;
                    tvalid_d = 1'b1;
                    if (sel_tlast) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any beat in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(PORTS - 1);
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tid_q        <= '0;
            tvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tid_q        <= tid_d;
            tvalid_q     <= tvalid_d;
        end
    end

    assign axis.s_axis_tready = s_tready;
    assign axis.m_axis_tdata  = tdata_q;
    assign axis.m_axis_tvalid = tvalid_q;
    assign axis.m_axis_tlast  = tlast_q;
    assign axis.m_axis_tuser  = tuser_q;
    assign axis.m_axis_tid    = tid_q;
    assign busy               = (state_q == BUSY);

endmodule
